// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Holds widths, the NOP encoding and the fetch FSM states.
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      FETCH   = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } if_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Flush wins over load; neither asserted holds the current contents.
module if_id_reg
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic               i_flush,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [31:0]        i_pc4,
   output logic [INSTR_W-1:0] o_instr,
   output logic [31:0]        o_pc4,
   output logic               o_valid
);

   logic [INSTR_W-1:0] r_instr;
   logic [31:0]        r_pc4;
   logic               r_valid;

   // bubble on flush, capture on load, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= NOP_INSTR;
         r_pc4   <= 32'h0;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc4   <= i_pc4;
         r_valid <= 1'b1;
      end
   end

   assign o_instr = r_instr;
   assign o_pc4   = r_pc4;
   assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem handshake, skid and redirect.
// Request/address come from state and pc only, so they stay stable.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic [INSTR_W-1:0] instruction,
   output logic [31:0]        pc_plus4,
   output logic               if_valid
);

   if_state_t          r_state, w_nxt_state;
   logic [31:0]        r_pc, w_nxt_pc;
   logic [INSTR_W-1:0] r_skid, w_nxt_skid;
   logic [31:0]        r_pend, w_nxt_pend;
   logic [31:0]        w_pc_inc;
   logic               w_load, w_flush;
   logic [INSTR_W-1:0] w_d_instr;
   logic [31:0]        w_d_pc4;

   assign w_pc_inc  = r_pc + 32'd4;
   assign imem_req  = (r_state == FETCH) || (r_state == DISCARD);
   assign imem_addr = r_pc;

   // next-state, pc/skid/pending updates and IF/ID controls
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pc    = r_pc;
      w_nxt_skid  = r_skid;
      w_nxt_pend  = r_pend;
      w_load      = 1'b0;
      w_flush     = 1'b0;
      w_d_instr   = imem_rdata;
      w_d_pc4     = w_pc_inc;
      unique case (r_state)
         BOOT: w_nxt_state = FETCH;
         FETCH: begin
            if (redirect && imem_ready) begin
               w_nxt_pc = redirect_pc;
               w_flush  = 1'b1;
            end else if (redirect) begin
               w_nxt_pend  = redirect_pc;
               w_flush     = 1'b1;
               w_nxt_state = DISCARD;
            end else if (stall && imem_ready) begin
               w_nxt_skid  = imem_rdata;
               w_nxt_pc    = w_pc_inc;
               w_nxt_state = HOLD;
            end else if (stall) begin
               w_nxt_state = FETCH;
            end else if (imem_ready) begin
               w_load   = 1'b1;
               w_nxt_pc = w_pc_inc;
            end else begin
               w_flush = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               w_nxt_skid  = NOP_INSTR;
               w_nxt_pc    = redirect_pc;
               w_flush     = 1'b1;
               w_nxt_state = FETCH;
            end else if (!stall) begin
               w_load      = 1'b1;
               w_d_instr   = r_skid;
               w_d_pc4     = r_pc;
               w_nxt_state = FETCH;
            end
         end
         DISCARD: begin
            w_flush = 1'b1;
            if (redirect) w_nxt_pend = redirect_pc;
            if (imem_ready) begin
               w_nxt_pc    = redirect ? redirect_pc : r_pend;
               w_nxt_state = FETCH;
            end
         end
         default: w_nxt_state = BOOT;
      endcase
   end

   // state, pc, skid and pending redirect registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
         r_pc    <= RESET_PC;
         r_skid  <= NOP_INSTR;
         r_pend  <= 32'h0;
      end else begin
         r_state <= w_nxt_state;
         r_pc    <= w_nxt_pc;
         r_skid  <= w_nxt_skid;
         r_pend  <= w_nxt_pend;
      end
   end

   if_id_reg u_if_id (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_instr (w_d_instr),
      .i_pc4   (w_d_pc4),
      .o_instr (instruction),
      .o_pc4   (pc_plus4),
      .o_valid (if_valid)
   );

endmodule
